// File: rtl/adc_spi_master.sv
// Byte-wide SPI master for the ADC configuration bus (SCLK/MOSI/MISO only).
// Ports: clk, rstn, i_tx_byte/i_tx_dv/o_tx_ready in, o_rx_dv/o_rx_byte out, SPI pins.
module adc_spi_master #(
   parameter int CLKS_PER_HALF_BIT = 2,
   parameter int SPI_MODE          = 0
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic [7:0] i_tx_byte,
   input  logic       i_tx_dv,
   output logic       o_tx_ready,
   output logic       o_rx_dv,
   output logic [7:0] o_rx_byte,
   output logic       o_spi_clk,
   output logic       o_spi_mosi,
   input  logic       i_spi_miso
);

   localparam logic [1:0] MODE = 2'(SPI_MODE);
   localparam logic       CPOL = MODE[1];
   localparam logic       CPHA = MODE[0];
   localparam int         CW   = $clog2(CLKS_PER_HALF_BIT + 1);
   localparam logic [CW-1:0] HMAX = CW'(CLKS_PER_HALF_BIT - 1);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SHIFT,
      ST_DONE
   } state_t;

   state_t        state_q, state_d;
   logic [7:0]    tx_q, tx_d;
   logic [7:0]    rx_sr_q, rx_sr_d;
   logic [7:0]    rx_byte_q, rx_byte_d;
   logic          rx_dv_q, rx_dv_d;
   logic          rdy_q, rdy_d;
   logic          sclk_q, sclk_d;
   logic          mosi_q, mosi_d;
   logic [CW-1:0] hcnt_q, hcnt_d;
   logic [4:0]    ecnt_q, ecnt_d;

   // ecnt counts SCLK transitions; even values precede a leading edge
   logic          lead;
   logic [2:0]    bidx;
   logic [2:0]    nidx;

   always_comb begin
      state_d   = state_q;
      tx_d      = tx_q;
      rx_sr_d   = rx_sr_q;
      rx_byte_d = rx_byte_q;
      rx_dv_d   = 1'b0;
      rdy_d     = rdy_q;
      sclk_d    = sclk_q;
      mosi_d    = mosi_q;
      hcnt_d    = hcnt_q;
      ecnt_d    = ecnt_q;
      lead      = ~ecnt_q[0];
      bidx      = ecnt_q[3:1];
      nidx      = bidx + 3'd1;

      unique case (state_q)
         ST_IDLE: begin
            if (i_tx_dv && rdy_q) begin
               tx_d    = i_tx_byte;
               rx_sr_d = 8'h00;
               rdy_d   = 1'b0;
               hcnt_d  = '0;
               ecnt_d  = '0;
               state_d = ST_SHIFT;
               // CPHA=0 must present bit7 before the first leading edge
               if (!CPHA) begin
                  mosi_d = i_tx_byte[7];
               end
            end
         end
         ST_SHIFT: begin
            if (hcnt_q == HMAX) begin
               hcnt_d = '0;
               sclk_d = ~sclk_q;
               ecnt_d = ecnt_q + 5'd1;
               if (!CPHA) begin
                  if (lead) begin
                     rx_sr_d = {rx_sr_q[6:0], i_spi_miso};
                  end else if (bidx != 3'd7) begin
                     mosi_d = tx_q[~nidx];
                  end
               end else begin
                  if (lead) begin
                     mosi_d = tx_q[~bidx];
                  end else begin
                     rx_sr_d = {rx_sr_q[6:0], i_spi_miso};
                  end
               end
               if (ecnt_q == 5'd15) begin
                  state_d = ST_DONE;
               end
            end else begin
               hcnt_d = hcnt_q + 1'b1;
            end
         end
         ST_DONE: begin
            rx_byte_d = rx_sr_q;
            rx_dv_d   = 1'b1;
            rdy_d     = 1'b1;
            state_d   = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
            rdy_d   = 1'b1;
            sclk_d  = CPOL;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q   <= ST_IDLE;
         tx_q      <= 8'h00;
         rx_sr_q   <= 8'h00;
         rx_byte_q <= 8'h00;
         rx_dv_q   <= 1'b0;
         rdy_q     <= 1'b1;
         sclk_q    <= CPOL;
         mosi_q    <= 1'b0;
         hcnt_q    <= '0;
         ecnt_q    <= '0;
      end else begin
         state_q   <= state_d;
         tx_q      <= tx_d;
         rx_sr_q   <= rx_sr_d;
         rx_byte_q <= rx_byte_d;
         rx_dv_q   <= rx_dv_d;
         rdy_q     <= rdy_d;
         sclk_q    <= sclk_d;
         mosi_q    <= mosi_d;
         hcnt_q    <= hcnt_d;
         ecnt_q    <= ecnt_d;
      end
   end

   assign o_tx_ready = rdy_q;
   assign o_rx_dv    = rx_dv_q;
   assign o_rx_byte  = rx_byte_q;
   assign o_spi_clk  = sclk_q;
   assign o_spi_mosi = mosi_q;

endmodule

// File: tb/tb_adc_spi_master.sv
// Bench for adc_spi_master: modes 0 (H=2), 3 (H=4) and 1 (H=1).
// Expected rx bytes and due cycles are queued at request time.
module tb_adc_spi_master;

   typedef struct {
      logic [7:0] data;
      int         due;
   } exp_t;

   logic clk = 1'b0;
   initial forever #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   logic rstn = 1'b0;

   exp_t q0[$];
   exp_t q3[$];
   exp_t q1[$];

   logic [7:0] tx0 = 8'h00;
   logic       dv0 = 1'b0;
   logic       rdy0, rxdv0, sclk0, mosi0, miso0;
   logic [7:0] rx0;

   logic [7:0] tx3 = 8'h00;
   logic       dv3 = 1'b0;
   logic       rdy3, rxdv3, sclk3, mosi3, miso3;
   logic [7:0] rx3;

   logic [7:0] tx1 = 8'h00;
   logic       dv1 = 1'b0;
   logic       rdy1, rxdv1, sclk1, mosi1, miso1;
   logic [7:0] rx1;

   // ADC model for mode 0: next bit is presented after each rising SCLK
   logic       adc_en = 1'b0;
   logic [7:0] adc_byte = 8'h00;
   int         rise0 = 0;
   int         base0 = 0;
   always @(posedge sclk0) rise0 <= rise0 + 1;
   assign miso0 = adc_en ? adc_byte[3'(7 - (rise0 - base0))] : mosi0;
   assign miso3 = mosi3;
   assign miso1 = 1'b1;

   adc_spi_master #(.CLKS_PER_HALF_BIT(2), .SPI_MODE(0)) dut0 (
      .clk(clk), .rstn(rstn),
      .i_tx_byte(tx0), .i_tx_dv(dv0), .o_tx_ready(rdy0),
      .o_rx_dv(rxdv0), .o_rx_byte(rx0),
      .o_spi_clk(sclk0), .o_spi_mosi(mosi0), .i_spi_miso(miso0)
   );

   adc_spi_master #(.CLKS_PER_HALF_BIT(4), .SPI_MODE(3)) dut3 (
      .clk(clk), .rstn(rstn),
      .i_tx_byte(tx3), .i_tx_dv(dv3), .o_tx_ready(rdy3),
      .o_rx_dv(rxdv3), .o_rx_byte(rx3),
      .o_spi_clk(sclk3), .o_spi_mosi(mosi3), .i_spi_miso(miso3)
   );

   adc_spi_master #(.CLKS_PER_HALF_BIT(1), .SPI_MODE(1)) dut1 (
      .clk(clk), .rstn(rstn),
      .i_tx_byte(tx1), .i_tx_dv(dv1), .o_tx_ready(rdy1),
      .o_rx_dv(rxdv1), .o_rx_byte(rx1),
      .o_spi_clk(sclk1), .o_spi_mosi(mosi1), .i_spi_miso(miso1)
   );

   // Scoreboard pops: every rx_dv must match a queued byte and due cycle
   always @(negedge clk) begin
      if (rxdv0) begin
         checks++;
         if (q0.size() == 0) begin
            errors++;
            $display("FAIL sb0_unexpected: rx_dv with byte %0h, none expected", rx0);
         end else begin
            exp_t e;
            e = q0.pop_front();
            if (rx0 !== e.data || cyc !== e.due) begin
               errors++;
               $display("FAIL sb0: got %0h at cyc %0d, expected %0h at cyc %0d",
                        rx0, cyc, e.data, e.due);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rxdv3) begin
         checks++;
         if (q3.size() == 0) begin
            errors++;
            $display("FAIL sb3_unexpected: rx_dv with byte %0h, none expected", rx3);
         end else begin
            exp_t e;
            e = q3.pop_front();
            if (rx3 !== e.data || cyc !== e.due) begin
               errors++;
               $display("FAIL sb3: got %0h at cyc %0d, expected %0h at cyc %0d",
                        rx3, cyc, e.data, e.due);
            end
         end
      end
   end

   always @(negedge clk) begin
      if (rxdv1) begin
         checks++;
         if (q1.size() == 0) begin
            errors++;
            $display("FAIL sb1_unexpected: rx_dv with byte %0h, none expected", rx1);
         end else begin
            exp_t e;
            e = q1.pop_front();
            if (rx1 !== e.data || cyc !== e.due) begin
               errors++;
               $display("FAIL sb1: got %0h at cyc %0d, expected %0h at cyc %0d",
                        rx1, cyc, e.data, e.due);
            end
         end
      end
   end

   // Runs one mode-0 transfer starting at a negedge; returns at the rx_dv
   // negedge. Collects SCLK transitions, MOSI at rising edges and
   // handshake violations (ready level, bit7 at accept, timeout).
   task automatic run0(input logic [7:0] b, input logic [7:0] exp,
                       input int inj, output int trans,
                       output logic [7:0] seq, output int bad);
      int   a;
      logic prev;
      bit   done;
      trans = 0;
      seq   = 8'h00;
      bad   = 0;
      done  = 1'b0;
      prev  = sclk0;
      tx0   = b;
      dv0   = 1'b1;
      a     = cyc + 1;
      q0.push_back('{data: exp, due: a + 33});
      @(negedge clk);
      dv0 = 1'b0;
      if (mosi0 !== b[7]) bad++;
      for (int k = 0; k < 60 && !done; k++) begin
         if (sclk0 !== prev) begin
            trans++;
            if (sclk0) seq = {seq[6:0], mosi0};
            prev = sclk0;
         end
         if (rxdv0) begin
            done = 1'b1;
            if (rdy0 !== 1'b1) bad++;
         end else if (rdy0 !== 1'b0) begin
            bad++;
         end
         if (!done) begin
            if (inj > 0 && cyc == a + inj - 1) begin
               tx0 = 8'hFF;
               dv0 = 1'b1;
            end
            @(negedge clk);
            dv0 = 1'b0;
         end
      end
      if (!done) bad++;
   endtask

   task automatic test_reset();
      @(negedge clk);
      checks++;
      if (rdy0 !== 1'b1 || rxdv0 !== 1'b0 || rx0 !== 8'h00 ||
          sclk0 !== 1'b0 || mosi0 !== 1'b0) begin
         errors++;
         $display("FAIL reset0: rdy=%b dv=%b rx=%0h sclk=%b mosi=%b, need 1 0 00 0 0",
                  rdy0, rxdv0, rx0, sclk0, mosi0);
      end
      checks++;
      if (sclk3 !== 1'b1 || rdy3 !== 1'b1 || sclk1 !== 1'b0 || rdy1 !== 1'b1) begin
         errors++;
         $display("FAIL reset_other: sclk3=%b rdy3=%b sclk1=%b rdy1=%b, need 1 1 0 1",
                  sclk3, rdy3, sclk1, rdy1);
      end
      rstn = 1'b1;
      repeat (3) @(negedge clk);
      checks++;
      if (rdy0 !== 1'b1 || sclk0 !== 1'b0) begin
         errors++;
         $display("FAIL idle0: rdy=%b sclk=%b, need 1 0", rdy0, sclk0);
      end
   endtask

   task automatic test_single();
      int t, bad;
      logic [7:0] s;
      @(negedge clk);
      run0(8'hA5, 8'hA5, 0, t, s, bad);
      checks++;
      if (t !== 16) begin
         errors++;
         $display("FAIL single_trans: got %0d, need 16", t);
      end
      checks++;
      if (s !== 8'hA5) begin
         errors++;
         $display("FAIL single_mosi: got %0h, need a5", s);
      end
      checks++;
      if (bad !== 0) begin
         errors++;
         $display("FAIL single_hs: %0d violations, need 0", bad);
      end
      repeat (3) @(negedge clk);
      checks++;
      if (sclk0 !== 1'b0 || mosi0 !== 1'b1 || rx0 !== 8'hA5) begin
         errors++;
         $display("FAIL single_hold: sclk=%b mosi=%b rx=%0h, need 0 1 a5",
                  sclk0, mosi0, rx0);
      end
   endtask

   task automatic test_back_to_back();
      int t, bad;
      logic [7:0] s;
      logic [7:0] bytes [3];
      bytes[0] = 8'h80;
      bytes[1] = 8'h05;
      bytes[2] = 8'h00;
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) begin
            adc_byte = 8'h3C;
            base0    = rise0;
            adc_en   = 1'b1;
         end
         run0(bytes[i], (i == 2) ? 8'h3C : bytes[i], 0, t, s, bad);
         checks++;
         if (t !== 16 || s !== bytes[i] || bad !== 0) begin
            errors++;
            $display("FAIL b2b_%0d: trans=%0d mosi=%0h bad=%0d, need 16 %0h 0",
                     i, t, s, bad, bytes[i]);
         end
         checks++;
         if (sclk0 !== 1'b0) begin
            errors++;
            $display("FAIL b2b_gap_%0d: sclk=%b, need 0", i, sclk0);
         end
      end
      adc_en = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_ignore_busy();
      int t, bad;
      logic [7:0] s;
      @(negedge clk);
      run0(8'h12, 8'h12, 5, t, s, bad);
      checks++;
      if (t !== 16 || s !== 8'h12 || bad !== 0) begin
         errors++;
         $display("FAIL busy: trans=%0d mosi=%0h bad=%0d, need 16 12 0", t, s, bad);
      end
      repeat (40) @(negedge clk);
      checks++;
      if (rdy0 !== 1'b1 || rx0 !== 8'h12) begin
         errors++;
         $display("FAIL busy_after: rdy=%b rx=%0h, need 1 12", rdy0, rx0);
      end
   endtask

   task automatic test_reset_abort();
      int a, t, bad;
      logic [7:0] s;
      @(negedge clk);
      tx0 = 8'hE7;
      dv0 = 1'b1;
      a   = cyc + 1;
      @(negedge clk);
      dv0 = 1'b0;
      while (cyc < a + 10) @(negedge clk);
      checks++;
      if (sclk0 !== 1'b1 || mosi0 !== 1'b1 || rdy0 !== 1'b0) begin
         errors++;
         $display("FAIL abort_pre: sclk=%b mosi=%b rdy=%b, need 1 1 0",
                  sclk0, mosi0, rdy0);
      end
      rstn = 1'b0;
      #1;
      checks++;
      if (sclk0 !== 1'b0 || mosi0 !== 1'b0 || rdy0 !== 1'b1) begin
         errors++;
         $display("FAIL abort: sclk=%b mosi=%b rdy=%b, need 0 0 1",
                  sclk0, mosi0, rdy0);
      end
      repeat (2) @(negedge clk);
      rstn = 1'b1;
      repeat (40) @(negedge clk);
      run0(8'h5A, 8'h5A, 0, t, s, bad);
      checks++;
      if (t !== 16 || s !== 8'h5A || bad !== 0) begin
         errors++;
         $display("FAIL abort_next: trans=%0d mosi=%0h bad=%0d, need 16 5a 0",
                  t, s, bad);
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_mode3();
      int a, t, bad;
      logic [7:0] s;
      logic prev, pm;
      bit done;
      t = 0;
      bad = 0;
      s = 8'h00;
      done = 1'b0;
      @(negedge clk);
      checks++;
      if (sclk3 !== 1'b1) begin
         errors++;
         $display("FAIL m3_idle: sclk=%b, need 1", sclk3);
      end
      prev = sclk3;
      pm   = mosi3;
      tx3  = 8'hC3;
      dv3  = 1'b1;
      a    = cyc + 1;
      q3.push_back('{data: 8'hC3, due: a + 65});
      @(negedge clk);
      dv3 = 1'b0;
      for (int k = 0; k < 90 && !done; k++) begin
         if (mosi3 !== pm && !(prev === 1'b1 && sclk3 === 1'b0)) bad++;
         if (sclk3 !== prev) begin
            t++;
            if (sclk3) s = {s[6:0], mosi3};
         end
         prev = sclk3;
         pm   = mosi3;
         if (rxdv3) done = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!done || t !== 16 || s !== 8'hC3 || bad !== 0) begin
         errors++;
         $display("FAIL m3: done=%b trans=%0d mosi=%0h bad=%0d, need 1 16 c3 0",
                  done, t, s, bad);
      end
      @(negedge clk);
      checks++;
      if (sclk3 !== 1'b1 || rdy3 !== 1'b1) begin
         errors++;
         $display("FAIL m3_end: sclk=%b rdy=%b, need 1 1", sclk3, rdy3);
      end
   endtask

   task automatic test_mode1();
      int a, t;
      logic prev;
      bit done;
      t = 0;
      done = 1'b0;
      @(negedge clk);
      prev = sclk1;
      tx1  = 8'h00;
      dv1  = 1'b1;
      a    = cyc + 1;
      q1.push_back('{data: 8'hFF, due: a + 17});
      @(negedge clk);
      dv1 = 1'b0;
      for (int k = 0; k < 40 && !done; k++) begin
         if (sclk1 !== prev) t++;
         prev = sclk1;
         if (rxdv1) done = 1'b1;
         else @(negedge clk);
      end
      checks++;
      if (!done || t !== 16) begin
         errors++;
         $display("FAIL m1: done=%b trans=%0d, need 1 16", done, t);
      end
      @(negedge clk);
      checks++;
      if (rxdv1 !== 1'b0 || rx1 !== 8'hFF || sclk1 !== 1'b0) begin
         errors++;
         $display("FAIL m1_pulse: dv=%b rx=%0h sclk=%b, need 0 ff 0",
                  rxdv1, rx1, sclk1);
      end
   endtask

   task automatic test_drain();
      repeat (5) @(negedge clk);
      checks++;
      if (q0.size() != 0 || q3.size() != 0 || q1.size() != 0) begin
         errors++;
         $display("FAIL drain: pending %0d %0d %0d, need 0 0 0",
                  q0.size(), q3.size(), q1.size());
      end
   endtask

   initial begin
      test_reset();
      test_single();
      test_back_to_back();
      test_ignore_busy();
      test_reset_abort();
      test_mode3();
      test_mode1();
      test_drain();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/adc_spi_master.md
Name: adc_spi_master

Overview:
Byte-oriented SPI master that sits directly downstream of the command processor's SPI handshake (spitx/spitxdv/spitxready/spirx/spirxdv). It serialises one byte per request onto the ADC configuration bus and returns the byte shifted in from the ADC. Chip select stays with the command processor; this block only drives SCLK and MOSI and samples MISO.

Parameters:
CLKS_PER_HALF_BIT, 2, clk cycles per SCLK half-period; legal values are 1 or more.
SPI_MODE, 0, SPI mode 0..3. CPOL = SPI_MODE[1], CPHA = SPI_MODE[0].

Ports:
clk  input  1  system clock; all logic runs on its rising edge.
rstn  input  1  asynchronous, active-low reset.
i_tx_byte  input  8  byte to transmit; sampled on the accept edge.
i_tx_dv  input  1  transmit request; a single-cycle pulse is enough.
o_tx_ready  output  1  high when idle and a request can be accepted.
o_rx_dv  output  1  one-cycle pulse: o_rx_byte is valid.
o_rx_byte  output  8  byte received on MISO, MSB first.
o_spi_clk  output  1  SCLK.
o_spi_mosi  output  1  MOSI, MSB first.
i_spi_miso  input  1  MISO.

Behaviour:
- One clock domain. Reset is asynchronous and active-low, on ports clk and rstn (already decided).
- Reset values: o_tx_ready=1, o_rx_dv=0, o_rx_byte=8'h00, o_spi_clk=CPOL, o_spi_mosi=0. All internal counters are cleared.
- Reset mid-transfer aborts immediately: no o_rx_dv is produced and SCLK returns to CPOL.
- States:
  - IDLE: o_tx_ready=1 and SCLK=CPOL.
  - On a rising clk edge with i_tx_dv=1 and o_tx_ready=1 (call it the accept edge, A):
    - latch i_tx_byte;
    - drop o_tx_ready;
    - clear the bit counter;
    - move to SHIFT.
    - If CPHA=0, o_spi_mosi takes bit7 on edge A itself.
  - SHIFT: a half-period counter toggles o_spi_clk at edges A+H, A+2H, …, A+16H, where H=CLKS_PER_HALF_BIT. That gives exactly 16 SCLK transitions (8 leading, 8 trailing).
    - CPHA=0: MISO is sampled into the shift register on each leading transition (same clk edge that creates the transition). MOSI advances to the next bit on each trailing transition except the 8th.
    - CPHA=1: MOSI is updated on each leading transition (bit7 on the first). MISO is sampled on each trailing transition.
  - DONE, at edge A+16H+1:
    - o_rx_byte takes the assembled byte;
    - o_rx_dv=1 for exactly one cycle;
    - o_tx_ready=1 in the same cycle;
    - SCLK is already at CPOL.
- Transfer latency: accept edge to o_rx_dv is 16H+1 clk cycles. With the default H=2, o_rx_dv is high on edge A+33.
- i_tx_dv while o_tx_ready=0 is ignored. No queueing, and the in-flight byte is unaffected.
- i_tx_dv is accepted in the same cycle o_tx_ready returns high. This allows back-to-back bytes with 1 idle cycle. SCLK stays at CPOL for at least 1 clk between bytes.
- o_spi_mosi holds its last value between transfers. After the 8th bit it is not modified until the next accept.
- o_rx_byte holds its value until the next DONE.
- MISO is not synchronised. The ADC output is timed by the SCLK this block generates, and H is at least 1.

Test Plan:
1. Mode 0, H=2, MISO looped to MOSI; pulse i_tx_dv with 8'hA5 → 16 SCLK transitions, idle low; MOSI pattern 1,0,1,0,0,1,0,1; o_rx_dv at A+33 with o_rx_byte=8'hA5; o_tx_ready low from A+1 to A+32.
2. Command-processor sequence: three bytes 8'h80, 8'h05, 8'h00, each sent on the cycle o_tx_ready rises. ADC model drives 8'h3C during the third byte → three o_rx_dv pulses, the third carrying 8'h3C; exactly 1 idle cycle between bytes.
3. i_tx_dv with 8'hFF pulsed at A+5 during a transfer of 8'h12 → ignored; MOSI carries only 8'h12; only one o_rx_dv pulse.
4. rstn low at A+10 mid-transfer → SCLK=CPOL, MOSI=0 and o_tx_ready=1 immediately; no o_rx_dv; the next request of 8'h5A completes normally.
5. Mode 3, H=4, loopback 8'hC3 → SCLK idles high; MOSI changes on falling edges, MISO sampled on rising edges; o_rx_dv at A+65 with 8'hC3.
6. Mode 1, H=1, MISO tied high → o_rx_byte=8'hFF at A+17; o_rx_dv is a single-cycle pulse.
